// File: rtl/comparator_sweeper_if.sv
// Handshake and result bundle between a sweeper and the
// 1-bit comparator / controller it serves.
interface comparator_sweeper_if;
  logic       start;
  logic       eq;
  logic       i0;
  logic       i1;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic       fail_valid;

  modport master (
    output start,
    output eq,
    input  i0,
    input  i1,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_vec,
    input  fail_valid
  );

  modport slave (
    input  start,
    input  eq,
    output i0,
    output i1,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_vec,
    output fail_valid
  );
endinterface

// File: rtl/comparator_sweeper.sv
// Exhaustive sweep of a 1-bit equality comparator: drives all
// four operand pairs, checks eq against XNOR, reports results.
module comparator_sweeper #(
  parameter int HOLD_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  comparator_sweeper_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [1:0] v;
  logic [7:0] hc;
  logic       mis;

  assign mis = bus.eq != (bus.i0 ~^ bus.i1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      v              <= '0;
      hc             <= '0;
      bus.i0         <= 1'b0;
      bus.i1         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_cnt    <= '0;
      bus.fail_vec   <= '0;
      bus.fail_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= DRIVE;
            v              <= '0;
            hc             <= '0;
            bus.i0         <= 1'b0;
            bus.i1         <= 1'b0;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err_cnt    <= '0;
            bus.fail_vec   <= '0;
            bus.fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (hc == HC_LAST) begin
            if (mis) begin
              bus.err_cnt <= bus.err_cnt + 3'd1;
              if (!bus.fail_valid) begin
                bus.fail_vec   <= {bus.i0, bus.i1};
                bus.fail_valid <= 1'b1;
              end
            end
            hc <= '0;
            if (v == 2'b11) begin
              // pass must include the final vector's outcome
              state    <= DONE;
              bus.i0   <= 1'b0;
              bus.i1   <= 1'b0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (bus.err_cnt == 3'd0) && !mis;
            end else begin
              v      <= v + 2'd1;
              bus.i0 <= v[1] ^ v[0];
              bus.i1 <= ~v[0];
            end
          end else begin
            hc <= hc + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweeper.sv
// Randomized self-checking bench for comparator_sweeper with
// HOLD_CYCLES of 4 and 1 against a table-driven comparator model.
module tb_comparator_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comparator_sweeper_if bus4();
  comparator_sweeper_if bus1();

  logic [3:0] tbl4 = 4'b1001;
  logic [3:0] tbl1 = 4'b1001;

  assign bus4.eq = tbl4[{bus4.i0, bus4.i1}];
  assign bus1.eq = tbl1[{bus1.i0, bus1.i1}];

  comparator_sweeper #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  comparator_sweeper #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] seq[$];
  bit clr_ok;

  function automatic void model(
    input  logic [3:0] tbl,
    output int         errs,
    output logic [1:0] fv,
    output bit         fvalid
  );
    errs = 0; fv = 2'b00; fvalid = 0;
    for (int v = 0; v < 4; v++) begin
      bit good = (v == 0) || (v == 3);
      if (tbl[v] != good) begin
        errs++;
        if (!fvalid) begin
          fv = 2'(v);
          fvalid = 1;
        end
      end
    end
  endfunction

  function automatic logic [9:0] outs(input bit sel);
    if (sel)
      return {bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
              bus1.fail_vec, bus1.fail_valid, bus1.i0};
    return {bus4.busy, bus4.done, bus4.pass, bus4.err_cnt,
            bus4.fail_vec, bus4.fail_valid, bus4.i0};
  endfunction

  task automatic set_start(input bit sel, input logic val);
    if (sel) bus1.start = val;
    else bus4.start = val;
  endtask

  task automatic run_sweep(
    input  bit sel,
    input  int restart_at,
    output int bc
  );
    logic [9:0] o;
    seq.delete();
    bc = 0;
    @(negedge clk) set_start(sel, 1'b1);
    @(negedge clk) set_start(sel, 1'b0);
    o = outs(sel);
    clr_ok = (o[8:1] == 8'h00);
    while (outs(sel)[9] && bc < 1000) begin
      if (sel) seq.push_back({bus1.i0, bus1.i1});
      else seq.push_back({bus4.i0, bus4.i1});
      set_start(sel, logic'(bc == restart_at));
      bc++;
      @(negedge clk);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus4.start = 1'b1;
    bus1.start = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs(0) !== 10'd0 || bus4.i1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4 got %b exp 0", outs(0));
    end
    n_chk++;
    if (outs(1) !== 10'd0 || bus1.i1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset1 got %b exp 0", outs(1));
    end
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs(0) !== 10'd0) begin
      n_fail++;
      $display("FAIL idle4 got %b exp 0", outs(0));
    end
  endtask

  task automatic test_correct;
    int bc;
    bit seq_ok;
    tbl4 = 4'b1001;
    run_sweep(0, -1, bc);
    n_chk++;
    if (bc != 16) begin
      n_fail++;
      $display("FAIL busy_len got %0d exp 16", bc);
    end
    seq_ok = (seq.size() == 16);
    for (int k = 0; k < seq.size(); k++)
      if (seq[k] != 2'(k / 4)) seq_ok = 0;
    n_chk++;
    if (!seq_ok) begin
      n_fail++;
      $display("FAIL vec_seq got %0d entries exp 16 in order",
               seq.size());
    end
    n_chk++;
    if (outs(0) !== 10'b0110000000) begin
      n_fail++;
      $display("FAIL correct_res got %b exp 0110000000", outs(0));
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (outs(0) !== 10'b0110000000 || bus4.i1 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_stable got %b exp 0110000000", outs(0));
    end
  endtask

  task automatic test_faults;
    logic [3:0] tbls[$];
    int bc, errs;
    logic [1:0] fv;
    bit fvalid;
    tbls = '{4'b0110, 4'b0000, 4'b1111};
    repeat (8) tbls.push_back(4'($urandom));
    foreach (tbls[t]) begin
      tbl4 = tbls[t];
      model(tbl4, errs, fv, fvalid);
      run_sweep(0, -1, bc);
      n_chk++;
      if (!clr_ok) begin
        n_fail++;
        $display("FAIL clear_on_start tbl %b not cleared", tbl4);
      end
      n_chk++;
      if (bc != 16) begin
        n_fail++;
        $display("FAIL fault_len tbl %b got %0d exp 16", tbl4, bc);
      end
      n_chk++;
      if (bus4.err_cnt !== 3'(errs) || bus4.pass !== (errs == 0)
          || bus4.done !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_cnt tbl %b got %0d/%b exp %0d",
                 tbl4, bus4.err_cnt, bus4.pass, errs);
      end
      n_chk++;
      if (bus4.fail_valid !== fvalid || bus4.fail_vec !== fv) begin
        n_fail++;
        $display("FAIL fault_vec tbl %b got %b/%b exp %b/%b",
                 tbl4, bus4.fail_valid, bus4.fail_vec, fvalid, fv);
      end
    end
  endtask

  task automatic test_restart;
    int bc;
    tbl4 = 4'b0110;
    run_sweep(0, 5, bc);
    n_chk++;
    if (bc != 16) begin
      n_fail++;
      $display("FAIL restart_len got %0d exp 16", bc);
    end
    n_chk++;
    if (bus4.err_cnt !== 3'd4 || bus4.pass !== 1'b0 ||
        bus4.fail_vec !== 2'b00 || bus4.fail_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_res got %0d exp 4", bus4.err_cnt);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_tail got busy %b exp 0", bus4.busy);
    end
  endtask

  task automatic test_reset_mid;
    int bc;
    tbl4 = 4'b0110;
    @(negedge clk) bus4.start = 1'b1;
    @(negedge clk) bus4.start = 1'b0;
    repeat (9) @(negedge clk);
    n_chk++;
    if (bus4.busy !== 1'b1 || bus4.err_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_state got %b/%0d exp 1/2",
               bus4.busy, bus4.err_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (outs(0) !== 10'd0 || bus4.i1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got %b exp 0", outs(0));
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (outs(0) !== 10'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b exp 0", outs(0));
    end
    tbl4 = 4'b1001;
    run_sweep(0, -1, bc);
    n_chk++;
    if (bc != 16 || outs(0) !== 10'b0110000000) begin
      n_fail++;
      $display("FAIL clean_after_reset got %0d/%b exp 16", bc, outs(0));
    end
  endtask

  task automatic test_hold1;
    int bc;
    bit seq_ok;
    tbl1 = 4'b1001;
    run_sweep(1, -1, bc);
    n_chk++;
    if (bc != 4) begin
      n_fail++;
      $display("FAIL h1_len got %0d exp 4", bc);
    end
    seq_ok = (seq.size() == 4);
    for (int k = 0; k < seq.size(); k++)
      if (seq[k] != 2'(k)) seq_ok = 0;
    n_chk++;
    if (!seq_ok) begin
      n_fail++;
      $display("FAIL h1_seq got %0d entries exp 00,01,10,11",
               seq.size());
    end
    n_chk++;
    if (outs(1) !== 10'b0110000000) begin
      n_fail++;
      $display("FAIL h1_res got %b exp 0110000000", outs(1));
    end
    tbl1 = 4'b1111;
    run_sweep(1, -1, bc);
    n_chk++;
    if (bc != 4 || bus1.err_cnt !== 3'd2 ||
        bus1.fail_vec !== 2'b01 || bus1.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL h1_stuck1 got %0d/%b exp 2/01",
               bus1.err_cnt, bus1.fail_vec);
    end
  endtask

  initial begin
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_correct();
    test_faults();
    test_restart();
    test_reset_mid();
    test_hold1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_sweeper.md
COMPARATOR_SWEEPER -- requirements
Module: comparator_sweeper

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles each input vector is held before eq is sampled (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to run one sweep.
REQ-005 SHALL have port eq  input  1  equality result returned by the 1-bit comparator under test.
REQ-006 SHALL have port i0  output  1  first comparator operand, registered.
REQ-007 SHALL have port i1  output  1  second comparator operand, registered.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  high from sweep completion until the next start or reset.
REQ-010 SHALL have port pass  output  1  valid while done: 1 when no mismatches were recorded.
REQ-011 SHALL have port err_cnt  output  3  number of mismatching vectors in the last sweep (0..4).
REQ-012 SHALL have port fail_vec  output  2  {i0,i1} of the first mismatching vector.
REQ-013 SHALL have port fail_valid  output  1  high when fail_vec holds a captured vector.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-015 SHALL go IDLE->DRIVE or DONE->DRIVE on the cycle after start=1 is sampled, clearing err_cnt, pass, fail_vec, fail_valid and done at that edge.
REQ-016 SHALL ignore start while in DRIVE: no restart, no counter change.
REQ-017 SHALL step a 2-bit vector index v through 00,01,10,11 in order, driving i0=v[1], i1=v[0].
REQ-018 SHALL hold each vector for exactly HOLD_CYCLES cycles using a hold counter hc counting 0..HOLD_CYCLES-1.
REQ-019 SHALL sample eq on the cycle where hc==HOLD_CYCLES-1 and compare it with expected (i0 XNOR i1).
REQ-020 SHALL, on a mismatch, increment err_cnt by 1 (saturation not needed, max 4), and if fail_valid=0 load fail_vec={i0,i1} and set fail_valid=1.
REQ-021 SHALL advance v and reset hc to 0 on the edge after each sample; after the sample of v=11, go to DONE.
REQ-022 SHALL keep busy=1 for exactly 4*HOLD_CYCLES consecutive cycles per sweep (all DRIVE cycles).
REQ-023 SHALL set done=1 and pass=(err_cnt==0, including any increment from the final sample) on the first DONE cycle, with busy=0.
REQ-024 SHALL keep i0=i1=0 in IDLE and DONE.
REQ-025 SHALL, with HOLD_CYCLES=1, sample eq on every DRIVE cycle, giving a 4-cycle sweep.
REQ-026 SHALL stay in DONE with all results stable until start or reset; start in DONE begins a fresh sweep per REQ-015.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, force state IDLE, v=0, hc=0, i0=i1=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=00, fail_valid=0.
REQ-028 SHALL abort any sweep in progress on reset, with no partial results retained.
REQ-029 SHALL give reset priority over start in the same cycle.

Verification
REQ-030 SHALL verify: correct comparator, HOLD_CYCLES=4, start pulse -> busy for 16 cycles, then done=1, pass=1, err_cnt=0, fail_valid=0.
REQ-031 SHALL verify: eq driven inverted (i0 XOR i1) -> err_cnt=4, pass=0, fail_vec=00, fail_valid=1.
REQ-032 SHALL verify: eq stuck at 0 -> err_cnt=2, fail_vec=00; eq stuck at 1 -> err_cnt=2, fail_vec=01.
REQ-033 SHALL verify: start re-pulsed at DRIVE cycle 5 -> sweep still ends after 16 busy cycles with unchanged result; start in DONE -> results cleared and new sweep.
REQ-034 SHALL verify: rst_n=0 at DRIVE cycle 9 -> next cycle all outputs at reset values, state IDLE; a later start gives a full clean sweep.
REQ-035 SHALL verify: HOLD_CYCLES=1 with correct comparator -> busy 4 cycles, i0/i1 sequence 00,01,10,11, pass=1.
